// File: rtl/uart_tx_arb_if.sv
// rtl/uart_tx_arb_if.sv - byte stream bundle shared by the requesters and the UART-side sink
interface uart_tx_arb_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   // The transmitter side carries no packet framing, so tlast is absent from master.
   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - two-requester round-robin packet arbiter feeding a UART transmitter
module uart_tx_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_arb_if.slave       s0_axis,
   uart_tx_arb_if.slave       s1_axis,
   uart_tx_arb_if.master      m_axis,
   output logic [1:0]         grant,
   output logic               burst_cut
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

   state_t                state;
   state_t                state_nxt;
   logic                  last_grant;
   logic [7:0]            beat_cnt;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;

   logic                  out_ready;
   logic                  s0_ready;
   logic                  s1_ready;
   logic                  acc0;
   logic                  acc1;
   logic                  acc;
   logic [DATA_WIDTH-1:0] acc_data;
   logic                  acc_last;
   logic                  at_limit;
   logic                  end_grant;
   logic                  cut;

   // The output register can take a new beat when empty or draining this cycle.
   assign out_ready = !m_valid || m_axis.tready;
   assign s0_ready  = (state == GNT0) && out_ready;
   assign s1_ready  = (state == GNT1) && out_ready;

   assign s0_axis.tready = s0_ready;
   assign s1_axis.tready = s1_ready;
   assign m_axis.tvalid  = m_valid;
   assign m_axis.tdata   = m_data;
   assign grant          = {state == GNT1, state == GNT0};

   assign acc0      = s0_axis.tvalid && s0_ready;
   assign acc1      = s1_axis.tvalid && s1_ready;
   assign acc       = acc0 || acc1;
   assign acc_data  = acc0 ? s0_axis.tdata : s1_axis.tdata;
   assign acc_last  = acc0 ? s0_axis.tlast : s1_axis.tlast;
   assign at_limit  = (beat_cnt == LAST_BEAT);
   assign end_grant = acc && (acc_last || at_limit);
   assign cut       = acc && !acc_last && at_limit;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (s0_axis.tvalid && s1_axis.tvalid) begin
               state_nxt = last_grant ? GNT0 : GNT1;
            end else if (s0_axis.tvalid) begin
               state_nxt = GNT0;
            end else if (s1_axis.tvalid) begin
               state_nxt = GNT1;
            end
         end
         GNT0, GNT1: begin
            if (end_grant) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         beat_cnt   <= 8'd0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         burst_cut  <= 1'b0;
      end else begin
         state     <= state_nxt;
         burst_cut <= cut;
         // Counter is zero on every grant entry because IDLE always precedes a grant.
         if (state == IDLE) begin
            beat_cnt <= 8'd0;
         end else if (acc) begin
            beat_cnt <= beat_cnt + 8'd1;
         end
         if (end_grant) begin
            last_grant <= (state == GNT1);
         end
         if (acc) begin
            m_valid <= 1'b1;
            m_data  <= acc_data;
         end else if (m_axis.tready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - scoreboard bench for uart_tx_arb
module tb_uart_tx_arb;
   localparam int DW = 8;
   localparam int MB = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] grant;
   logic burst_cut;

   always #5 clk = ~clk;

   uart_tx_arb_if #(.DATA_WIDTH(DW)) s0_if ();
   uart_tx_arb_if #(.DATA_WIDTH(DW)) s1_if ();
   uart_tx_arb_if #(.DATA_WIDTH(DW)) m_if ();

   uart_tx_arb #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s0_axis   (s0_if),
      .s1_axis   (s1_if),
      .m_axis    (m_if),
      .grant     (grant),
      .burst_cut (burst_cut)
   );

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int cut_cnt = 0;
   int cut_cyc = 0;
   int first_cyc[2];
   int last_cyc[2];
   int acc_cnt[2];
   int beat_cyc0[128];
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard for every beat the sink takes.
   always begin
      @(negedge clk);
      #2;
      if (burst_cut) begin
         cut_cnt++;
         cut_cyc = cyc;
      end
      if (rst_n && m_if.tvalid && m_if.tready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL m_extra_beat: got %h, expected no beat", m_if.tdata);
         end else begin
            exp_v = exp_q.pop_front();
            if (m_if.tdata !== exp_v) begin
               n_fail++;
               $display("FAIL m_data: got %h, expected %h", m_if.tdata, exp_v);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic set_src(input int id, input logic v, input logic [7:0] d, input logic l);
      if (id == 0) begin
         s0_if.tvalid = v; s0_if.tdata = d; s0_if.tlast = l;
      end else begin
         s1_if.tvalid = v; s1_if.tdata = d; s1_if.tlast = l;
      end
   endtask

   function automatic logic src_ready(input int id);
      return (id == 0) ? s0_if.tready : s1_if.tready;
   endfunction

   task automatic clear_stats();
      for (int k = 0; k < 2; k++) begin
         first_cyc[k] = 0; last_cyc[k] = 0; acc_cnt[k] = 0;
      end
      cut_cnt = 0;
      cut_cyc = 0;
   endtask

   task automatic drive_src(input int id, input logic [7:0] base, input int n,
                            input int gap_after, input int gap_len);
      logic [1:0] eg;
      eg = (id == 0) ? 2'b01 : 2'b10;
      for (int i = 0; i < n; i++) begin
         int t;
         @(negedge clk);
         set_src(id, 1'b1, base + 8'(i), (i == n - 1));
         t = 0;
         #1;
         while (!src_ready(id)) begin
            t++;
            if (t > 2000) begin
               n_checks++;
               n_fail++;
               $display("FAIL src%0d_timeout: beat %0d not accepted, expected acceptance", id, i);
               set_src(id, 1'b0, 8'h00, 1'b0);
               return;
            end
            @(negedge clk);
            #1;
         end
         n_checks++;
         if (grant !== eg) begin
            n_fail++;
            $display("FAIL src%0d_grant: got %b, expected %b", id, grant, eg);
         end
         if (acc_cnt[id] == 0) first_cyc[id] = cyc;
         last_cyc[id] = cyc;
         acc_cnt[id]++;
         if (id == 0 && i < 128) beat_cyc0[i] = cyc;
         if (i == gap_after) begin
            @(negedge clk);
            set_src(id, 1'b0, 8'h00, 1'b0);
            repeat (gap_len) @(negedge clk);
         end
      end
      @(negedge clk);
      set_src(id, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #2;
      n_checks += 6;
      if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m_tvalid: got %b, expected 0", m_if.tvalid); end
      if (m_if.tdata !== 8'h00) begin n_fail++; $display("FAIL rst_m_tdata: got %h, expected 00", m_if.tdata); end
      if (grant !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b, expected 00", grant); end
      if (burst_cut !== 1'b0) begin n_fail++; $display("FAIL rst_burst_cut: got %b, expected 0", burst_cut); end
      if (s0_if.tready !== 1'b0) begin n_fail++; $display("FAIL rst_s0_tready: got %b, expected 0", s0_if.tready); end
      if (s1_if.tready !== 1'b0) begin n_fail++; $display("FAIL rst_s1_tready: got %b, expected 0", s1_if.tready); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      clear_stats();
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h41 + 8'(i));
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h61 + 8'(i));
      fork
         drive_src(0, 8'h41, 3, -1, 0);
         drive_src(1, 8'h61, 3, -1, 0);
      join
      wait_drain();
      n_checks += 3;
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rr_drain: got %0d left, expected 0", exp_q.size()); end
      if (first_cyc[1] - last_cyc[0] !== 2) begin
         n_fail++;
         $display("FAIL rr_idle_gap: got %0d cycles, expected 2", first_cyc[1] - last_cyc[0]);
      end
      if (cut_cnt !== 0) begin n_fail++; $display("FAIL rr_no_cut: got %0d, expected 0", cut_cnt); end
      exp_q.delete();
   endtask

   task automatic test_burst_cut();
      clear_stats();
      for (int i = 0; i < 64; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'hA1);
      for (int i = 64; i < 100; i++) exp_q.push_back(8'(i));
      fork
         drive_src(0, 8'h00, 100, -1, 0);
         drive_src(1, 8'hA0, 2, -1, 0);
      join
      wait_drain();
      n_checks += 4;
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL cut_drain: got %0d left, expected 0", exp_q.size()); end
      if (cut_cnt !== 1) begin n_fail++; $display("FAIL cut_count: got %0d, expected 1", cut_cnt); end
      if (cut_cyc !== beat_cyc0[63] + 1) begin
         n_fail++;
         $display("FAIL cut_timing: got cycle %0d, expected %0d", cut_cyc, beat_cyc0[63] + 1);
      end
      if (!(first_cyc[1] > beat_cyc0[63] && first_cyc[1] < beat_cyc0[64])) begin
         n_fail++;
         $display("FAIL cut_s1_between: got cycle %0d, expected between %0d and %0d",
                  first_cyc[1], beat_cyc0[63], beat_cyc0[64]);
      end
      exp_q.delete();
   endtask

   task automatic test_burst_tlast();
      clear_stats();
      for (int i = 0; i < 64; i++) exp_q.push_back(8'h80 + 8'(i));
      drive_src(0, 8'h80, 64, -1, 0);
      wait_drain();
      n_checks += 2;
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL tl_drain: got %0d left, expected 0", exp_q.size()); end
      if (cut_cnt !== 0) begin n_fail++; $display("FAIL tl_no_cut: got %0d, expected 0", cut_cnt); end
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      logic [7:0] hold;
      clear_stats();
      for (int i = 0; i < 6; i++) exp_q.push_back(8'hC0 + 8'(i));
      fork
         drive_src(0, 8'hC0, 6, -1, 0);
         begin
            int t;
            t = 0;
            @(negedge clk);
            while (!(m_if.tvalid && acc_cnt[0] >= 2) && t < 200) begin
               @(negedge clk);
               t++;
            end
            m_if.tready = 1'b0;
            hold = m_if.tdata;
            for (int k = 0; k < 5; k++) begin
               #3;
               n_checks += 3;
               if (m_if.tdata !== hold) begin n_fail++; $display("FAIL bp_hold: got %h, expected %h", m_if.tdata, hold); end
               if (m_if.tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid: got %b, expected 1", m_if.tvalid); end
               if (s0_if.tready !== 1'b0) begin n_fail++; $display("FAIL bp_s0_tready: got %b, expected 0", s0_if.tready); end
               @(negedge clk);
            end
            m_if.tready = 1'b1;
         end
      join
      wait_drain();
      n_checks++;
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL bp_drain: got %0d left, expected 0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_hold_grant();
      clear_stats();
      for (int i = 0; i < 3; i++) exp_q.push_back(8'hE0 + 8'(i));
      for (int i = 0; i < 3; i++) exp_q.push_back(8'hD0 + 8'(i));
      fork
         drive_src(1, 8'hE0, 3, 0, 10);
         drive_src(0, 8'hD0, 3, -1, 0);
         begin
            int t;
            t = 0;
            @(negedge clk);
            #3;
            while (acc_cnt[1] < 1 && t < 200) begin
               @(negedge clk);
               #3;
               t++;
            end
            @(negedge clk);
            for (int k = 0; k < 10; k++) begin
               #3;
               n_checks += 2;
               if (grant !== 2'b10) begin n_fail++; $display("FAIL hold_grant: got %b, expected 10", grant); end
               if (s0_if.tready !== 1'b0) begin n_fail++; $display("FAIL hold_s0_tready: got %b, expected 0", s0_if.tready); end
               @(negedge clk);
            end
         end
      join
      wait_drain();
      n_checks++;
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL hold_drain: got %0d left, expected 0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int t;
      clear_stats();
      exp_q.push_back(8'h11);
      @(negedge clk);
      set_src(0, 1'b1, 8'h11, 1'b0);
      t = 0;
      #1;
      while (!s0_if.tready && t < 50) begin @(negedge clk); #1; t++; end
      @(negedge clk);
      set_src(0, 1'b1, 8'h12, 1'b0);
      t = 0;
      #1;
      while (!s0_if.tready && t < 50) begin @(negedge clk); #1; t++; end
      @(negedge clk);
      set_src(0, 1'b0, 8'h00, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      n_checks += 7;
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rm_first_beat: got %0d left, expected 0", exp_q.size()); end
      if (m_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL rm_m_tvalid: got %b, expected 0", m_if.tvalid); end
      if (m_if.tdata !== 8'h00) begin n_fail++; $display("FAIL rm_m_tdata: got %h, expected 00", m_if.tdata); end
      if (grant !== 2'b00) begin n_fail++; $display("FAIL rm_grant: got %b, expected 00", grant); end
      if (burst_cut !== 1'b0) begin n_fail++; $display("FAIL rm_burst_cut: got %b, expected 0", burst_cut); end
      if (s0_if.tready !== 1'b0) begin n_fail++; $display("FAIL rm_s0_tready: got %b, expected 0", s0_if.tready); end
      if (s1_if.tready !== 1'b0) begin n_fail++; $display("FAIL rm_s1_tready: got %b, expected 0", s1_if.tready); end
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(8'h21);
      exp_q.push_back(8'h31);
      fork
         drive_src(0, 8'h21, 1, -1, 0);
         drive_src(1, 8'h31, 1, -1, 0);
      join
      wait_drain();
      n_checks += 2;
      if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rm_drain: got %0d left, expected 0", exp_q.size()); end
      if (first_cyc[0] >= first_cyc[1]) begin
         n_fail++;
         $display("FAIL rm_first_tie: got s0 at %0d s1 at %0d, expected s0 first", first_cyc[0], first_cyc[1]);
      end
      exp_q.delete();
   endtask

   initial begin
      set_src(0, 1'b0, 8'h00, 1'b0);
      set_src(1, 1'b0, 8'h00, 1'b0);
      m_if.tready = 1'b1;
      m_if.tlast = 1'b0;
      test_reset();
      test_round_robin();
      test_burst_cut();
      test_burst_tlast();
      test_backpressure();
      test_hold_grant();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of all streams.
REQ-002 SHALL have parameter MAX_BURST, default 64, range 1..255, maximum beats per grant.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have ports s0_axis_tdata / tvalid / tready / tlast  in / in / out / in  DATA_WIDTH / 1 / 1 / 1  requester 0 stream.
REQ-006 SHALL have ports s1_axis_tdata / tvalid / tready / tlast  in / in / out / in  DATA_WIDTH / 1 / 1 / 1  requester 1 stream.
REQ-007 SHALL have ports m_axis_tdata / tvalid / tready  out / out / in  DATA_WIDTH / 1 / 1  stream to the UART transmitter's s_axis.
REQ-008 SHALL have port grant  output  2  one-hot current owner; 00 when idle.
REQ-009 SHALL have port burst_cut  output  1  one-cycle pulse when a grant is ended by MAX_BURST rather than tlast.

Function
REQ-010 SHALL implement states IDLE, GNT0 and GNT1; grant SHALL be 01 in GNT0, 10 in GNT1 and 00 in IDLE.
REQ-011 In IDLE, SHALL move to GNT0 if only s0 is valid and to GNT1 if only s1 is valid.
REQ-012 In IDLE with both valid, SHALL grant the requester not granted last (round-robin via last_grant register).
REQ-013 In IDLE with neither valid, SHALL remain in IDLE; the arbitration decision costs exactly one IDLE cycle between grants.
REQ-014 SHALL drive sX_axis_tready = (state==GNTX) && (!m_axis_tvalid || m_axis_tready); the non-granted tready SHALL be 0.
REQ-015 A beat is accepted when sX tvalid && tready; SHALL register tdata into m_axis_tdata and set m_axis_tvalid=1 on the next edge (latency 1 cycle).
REQ-016 If no beat is accepted and m_axis_tready=1, SHALL clear m_axis_tvalid; m_axis_tdata SHALL hold while m_axis_tvalid=1 && m_axis_tready=0.
REQ-017 Full throughput: with a continuously ready sink, SHALL accept one beat per cycle within a grant.
REQ-018 SHALL keep an 8-bit beat counter, cleared on grant entry and incremented per accepted beat.
REQ-019 On an accepted beat with tlast=1, SHALL go to IDLE and set last_grant to the current requester.
REQ-020 On an accepted beat with tlast=0 and counter==MAX_BURST-1, SHALL go to IDLE, set last_grant, and pulse burst_cut for 1 cycle.
REQ-021 When tlast and the MAX_BURST limit coincide on one beat, SHALL go to IDLE without pulsing burst_cut.
REQ-022 When the granted requester drops tvalid mid-packet, SHALL hold the grant indefinitely; no switch without tlast or the burst limit.
REQ-023 Changes to the non-granted requester's inputs SHALL have no effect during a grant.

Reset
REQ-024 On rst_n=0, SHALL asynchronously set: state=IDLE, last_grant=1 (s0 wins the first tie), counter=0, m_axis_tvalid=0, m_axis_tdata=0, grant=00, burst_cut=0, both s tready=0.
REQ-025 On reset mid-packet, a byte held in the output register SHALL be discarded; arbitration SHALL restart from IDLE after rst_n rises.

Verification
REQ-026 Both requesters valid after reset, each sending a 3-beat packet (s0: 0x41,0x42,0x43; s1: 0x61,0x62,0x63), sink always ready -> m stream is 41,42,43 then 61,62,63; grant is 01 then 10; one idle cycle between packets.
REQ-027 s0 sends a 100-beat packet with MAX_BURST=64 while s1 is valid -> burst_cut pulses once after beat 64; s1 is granted next; s0 resumes at beat 65 afterwards.
REQ-028 Sink backpressure (m_axis_tready=0 for 5 cycles while m_axis_tvalid=1) -> m_axis_tdata is stable, s0 tready=0, and no beat is lost or duplicated.
REQ-029 Granted s1 deasserts tvalid for 10 cycles mid-packet while s0 is valid -> grant stays 10 and s0_axis_tready stays 0.
REQ-030 Assert rst_n=0 during beat 2 of a packet -> all outputs reach reset values immediately; after release, the first tie is granted to s0.
